// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the multi-channel PWM tone mixer: channel mode
// encoding and an elaboration-time log2 helper used to size the mix adder.
package pwm_audio_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_SAW    = 1'b1;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_audio_voice.sv
// One tone channel: a phase accumulator stepped by its frequency word once
// per PWM period, plus the square/sawtooth sample and mute logic.
// Sawtooth support is only built when PWMAUDIO_SAW_EN is defined; otherwise
// every channel produces a square wave and the mode input is ignored.
module pwm_audio_voice
    import pwm_audio_pkg::*;
#(
    parameter int FREQ_W  = 8,
    parameter int PHASE_W = 16,
    parameter int PWM_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic [FREQ_W-1:0]  freq,
    input  logic               mode,
    output logic [PWM_W-1:0]   sample
);

    logic [PHASE_W-1:0] phase_r;
    logic               mute_s;
    logic [PWM_W-1:0]   square_s;

    assign mute_s   = (freq == {FREQ_W{1'b0}});
    assign square_s = phase_r[PHASE_W-1] ? {PWM_W{1'b1}} : {PWM_W{1'b0}};

    // Phase advances (or clears when muted) only on the period-end tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= {PHASE_W{1'b0}};
        end else if (tick) begin
            if (mute_s) begin
                phase_r <= {PHASE_W{1'b0}};
            end else begin
                phase_r <= phase_r + PHASE_W'(freq);
            end
        end else begin
            phase_r <= phase_r;
        end
    end

`ifdef PWMAUDIO_SAW_EN
    // Channel sample: muted channels contribute 0, otherwise square or saw.
    always_comb begin
        sample = {PWM_W{1'b0}};
        if (mute_s) begin
            sample = {PWM_W{1'b0}};
        end else if (mode == MODE_SAW) begin
            sample = phase_r[PHASE_W-1 -: PWM_W];
        end else begin
            sample = square_s;
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = mode;

    // Channel sample: muted channels contribute 0, otherwise square only.
    always_comb begin
        sample = {PWM_W{1'b0}};
        if (mute_s) begin
            sample = {PWM_W{1'b0}};
        end else begin
            sample = square_s;
        end
    end
`endif

endmodule

// File: rtl/pwm_audio_mixer.sv
// Multi-channel PWM tone mixer. CHANNELS voices are averaged once per PWM
// period into a duty value that drives a single registered PWM pin.
// Optional feature macro: PWMAUDIO_SAW_EN enables per-channel sawtooth mode.
module pwm_audio_mixer
    import pwm_audio_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int FREQ_W   = 8,
    parameter int PHASE_W  = 16,
    parameter int PWM_W    = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable_i,
    input  logic [CHANNELS*FREQ_W-1:0]          freq_i,
    input  logic [CHANNELS-1:0]                 mode_i,
    output logic                                pwm_o,
    output logic                                sample_o,
    output logic                                pwm_oeb_o,
    output logic [CHANNELS*FREQ_W+CHANNELS-1:0] in_oeb_o
);

    localparam int CH_LOG2 = clog2(CHANNELS);
    localparam int SUM_W   = PWM_W + CH_LOG2;
    localparam int IN_W    = CHANNELS * FREQ_W + CHANNELS;

    logic [PWM_W-1:0] cnt_r;
    logic [PWM_W-1:0] duty_r;
    logic             pwm_r;
    logic             tick_s;
    logic [PWM_W-1:0] voice_sample_s [CHANNELS];
    logic [SUM_W-1:0] sum_s;
    logic [PWM_W-1:0] mix_s;

    // Period end: last count of the period while running.
    assign tick_s = enable_i && (cnt_r == {PWM_W{1'b1}});

    for (genvar k = 0; k < CHANNELS; k++) begin : g_voice
        pwm_audio_voice #(
            .FREQ_W  (FREQ_W),
            .PHASE_W (PHASE_W),
            .PWM_W   (PWM_W)
        ) u_voice (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick_s),
            .freq    (freq_i[k*FREQ_W +: FREQ_W]),
            .mode    (mode_i[k]),
            .sample  (voice_sample_s[k])
        );
    end

    // Average of all channel samples; the wide sum cannot overflow.
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            sum_s = sum_s + SUM_W'(voice_sample_s[k]);
        end
        mix_s = PWM_W'(sum_s >> CH_LOG2);
    end

    // Period counter, duty register and PWM comparator flop; all hold and
    // the pin is forced low while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= {PWM_W{1'b0}};
            duty_r <= {PWM_W{1'b0}};
            pwm_r  <= 1'b0;
        end else if (enable_i) begin
            cnt_r  <= cnt_r + PWM_W'(1'b1);
            pwm_r  <= (cnt_r < duty_r);
            duty_r <= tick_s ? mix_s : duty_r;
        end else begin
            cnt_r  <= cnt_r;
            pwm_r  <= 1'b0;
            duty_r <= duty_r;
        end
    end

    assign pwm_o     = pwm_r;
    assign sample_o  = tick_s;
    assign pwm_oeb_o = 1'b0;
    assign in_oeb_o  = {IN_W{1'b1}};

endmodule

// File: tb/tb_pwm_audio_mixer.sv
// Scoreboard bench for pwm_audio_mixer. The stimulus process models each
// period at the arithmetic level (phases as integers, duty as the integer
// mean of channel samples) and queues the duty expected for every period;
// the monitor counts pwm_o high clocks per period and checks strobe spacing.
module tb_pwm_audio_mixer;

    localparam int CHANNELS = 2;
    localparam int FREQ_W   = 8;
    localparam int PHASE_W  = 16;
    localparam int PWM_W    = 8;
    localparam int PERIOD   = 1 << PWM_W;
    localparam int IN_W     = CHANNELS * FREQ_W + CHANNELS;
`ifdef PWMAUDIO_SAW_EN
    localparam bit SAW_EN = 1'b1;
`else
    localparam bit SAW_EN = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic                         enable_i;
    logic [CHANNELS*FREQ_W-1:0]   freq_i;
    logic [CHANNELS-1:0]          mode_i;
    logic                         pwm_o;
    logic                         sample_o;
    logic                         pwm_oeb_o;
    logic [IN_W-1:0]              in_oeb_o;

    pwm_audio_mixer #(
        .CHANNELS (CHANNELS),
        .FREQ_W   (FREQ_W),
        .PHASE_W  (PHASE_W),
        .PWM_W    (PWM_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable_i  (enable_i),
        .freq_i    (freq_i),
        .mode_i    (mode_i),
        .pwm_o     (pwm_o),
        .sample_o  (sample_o),
        .pwm_oeb_o (pwm_oeb_o),
        .in_oeb_o  (in_oeb_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int exp_q[$];
    int m_phase [CHANNELS];
    int m_duty;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference sample of one channel from its integer phase.
    function automatic int chan_sample(input int ph, input int fr, input bit md);
        if (fr == 0) return 0;
        if (SAW_EN && md) return ph / (1 << (PHASE_W - PWM_W));
        return (ph >= (1 << (PHASE_W - 1))) ? (1 << PWM_W) - 1 : 0;
    endfunction

    // Period-end update using the inputs present at that moment.
    task automatic model_period_end();
        int total;
        int fr;
        total = 0;
        for (int k = 0; k < CHANNELS; k++)
            total += chan_sample(m_phase[k], int'(freq_i[k*FREQ_W +: FREQ_W]), mode_i[k]);
        for (int k = 0; k < CHANNELS; k++) begin
            fr = int'(freq_i[k*FREQ_W +: FREQ_W]);
            m_phase[k] = (fr == 0) ? 0 : (m_phase[k] + fr) % (1 << PHASE_W);
        end
        m_duty = total / CHANNELS;
    endtask

    task automatic clock_cycle();
        @(posedge clk);
        #1;
    endtask

    // One PWM period; inputs change at change_at, optional disable gap at
    // disable_at, and abort_at returns early (before that cycle's edge).
    task automatic run_period(input int change_at,
                              input logic [CHANNELS*FREQ_W-1:0] nf,
                              input logic [CHANNELS-1:0] nm,
                              input int disable_at,
                              input int abort_at);
        exp_q.push_back(m_duty);
        for (int c = 0; c < PERIOD; c++) begin
            if (c == abort_at) return;
            if (c == change_at) begin
                freq_i = nf;
                mode_i = nm;
            end
            if (c == disable_at) begin
                enable_i = 1'b0;
                clock_cycle();
                check("pwm_low_when_disabled", int'(pwm_o), 0);
                repeat ($urandom_range(6, 1)) clock_cycle();
                enable_i = 1'b1;
            end
            if (c == PERIOD - 1) model_period_end();
            clock_cycle();
        end
    endtask

    // Monitor: high clocks per period vs queued duty, and strobe spacing.
    int  hi_cnt  = 0;
    int  en_cnt  = 0;
    bit  prev_s  = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            hi_cnt = 0;
            en_cnt = 0;
            prev_s = 1'b0;
            exp_q.delete();
        end else begin
            hi_cnt += int'(pwm_o);
            if (prev_s) begin
                if (exp_q.size() == 0) check("period_expectation_present", 0, 1);
                else check("period_high_clocks", hi_cnt, exp_q.pop_front());
                hi_cnt = 0;
            end
            if (enable_i) en_cnt++;
            if (sample_o) begin
                check("strobe_interval", en_cnt, PERIOD);
                en_cnt = 0;
            end
            prev_s = sample_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FREQ_W-1:0] ch1;
        int change_at;
        int disable_at;
        reset_n  = 1'b0;
        enable_i = 1'b0;
        freq_i   = '0;
        mode_i   = '0;
        m_duty   = 0;
        for (int k = 0; k < CHANNELS; k++) m_phase[k] = 0;
        repeat (3) clock_cycle();
        check("reset_pwm", int'(pwm_o), 0);
        check("reset_sample", int'(sample_o), 0);
        check("pwm_oeb", int'(pwm_oeb_o), 0);
        check("in_oeb", int'(in_oeb_o), (1 << IN_W) - 1);

        reset_n  = 1'b1;
        enable_i = 1'b1;

        // Idle: all channels muted, output stays low.
        repeat (4) run_period(-1, freq_i, mode_i, -1, -1);

        // Main run: ch0 fixed at 0xFF (long enough to wrap its phase),
        // ch1 and modes re-randomised mid-period every 16 periods.
        ch1 = 8'h00;
        for (int p = 0; p < 264; p++) begin
            change_at  = -1;
            disable_at = ((p % 37) == 5) ? int'($urandom_range(PERIOD - 1, 1)) : -1;
            if ((p % 16) == 0) begin
                ch1 = ($urandom_range(4, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
                change_at = $urandom_range(PERIOD - 2, 1);
            end
            run_period(change_at, {ch1, 8'hFF}, 2'($urandom), disable_at, -1);
        end

        // Asynchronous reset on a strobe cycle.
        run_period(-1, freq_i, mode_i, -1, PERIOD - 1);
        check("strobe_before_reset", int'(sample_o), 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm_o), 0);
        check("async_reset_sample", int'(sample_o), 0);
        for (int k = 0; k < CHANNELS; k++) m_phase[k] = 0;
        m_duty = 0;
        clock_cycle();
        clock_cycle();
        reset_n = 1'b1;
        repeat (6) run_period(-1, freq_i, mode_i, -1, -1);

        enable_i = 1'b0;
        repeat (3) clock_cycle();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
